cache_memory_lru_core: RTL and testbench

CACHE_MEMORY_LRU_CORE -- requirements
Module: cache_memory_lru

---
 rtl/cache_lru_pkg.sv | 20 ++
 rtl/lru_age_update.sv | 47 ++++
 rtl/cache_memory_lru_core.sv | 116 +++++++++++
 tb/tb_cache_memory_lru_core.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_lru_pkg.sv
// Shared parameters and types for the 4-way LRU cache core.
package cache_lru_pkg;

   localparam int unsigned DEF_CACHE_SIZE = 256;
   localparam int unsigned DEF_INDEX_BITS = 8;
   localparam int unsigned DEF_TAG_BITS   = 24;
   localparam int unsigned DEF_WAY_SIZE   = 4;
   localparam int unsigned DATA_BITS      = 32;
   localparam int unsigned NUM_WAYS       = 4;
   localparam int unsigned AGE_BITS       = 2;
   localparam int unsigned WAY_BITS       = 2;

   typedef logic [AGE_BITS-1:0] age_t;
   typedef logic [WAY_BITS-1:0] way_t;

   // Ages after reset: way0 is MRU, way3 is LRU.
   localparam logic [NUM_WAYS-1:0][AGE_BITS-1:0] RESET_AGES =
      {age_t'(3), age_t'(2), age_t'(1), age_t'(0)};

endpackage

// File: rtl/lru_age_update.sv
// Next-age and victim computation for one 4-way set.
module lru_age_update
   import cache_lru_pkg::*;
(
   input  logic [NUM_WAYS-1:0][AGE_BITS-1:0] ages,
   input  logic [NUM_WAYS-1:0]               valid,
   input  logic [WAY_BITS-1:0]               access_way,
   output logic [NUM_WAYS-1:0][AGE_BITS-1:0] ages_next_c,
   output logic [WAY_BITS-1:0]               victim_c
);

   age_t acc_age_c;
   logic found_c;

   // Accessed way becomes MRU; younger ways age by one.
   always_comb begin
      ages_next_c = ages;
      acc_age_c   = ages[access_way];
      for (int i = 0; i < int'(NUM_WAYS); i++) begin
         if (way_t'(i) == access_way) begin
            ages_next_c[i] = '0;
         end else if (ages[i] < acc_age_c) begin
            ages_next_c[i] = age_t'(ages[i] + age_t'(1));
         end
      end
   end

   // Victim: lowest invalid way, otherwise the way with the oldest age.
   always_comb begin
      victim_c = '0;
      found_c  = 1'b0;
      for (int i = 0; i < int'(NUM_WAYS); i++) begin
         if (!found_c && !valid[i]) begin
            victim_c = way_t'(i);
            found_c  = 1'b1;
         end
      end
      if (!found_c) begin
         for (int i = 0; i < int'(NUM_WAYS); i++) begin
            if (ages[i] == age_t'(NUM_WAYS - 1)) begin
               victim_c = way_t'(i);
            end
         end
      end
   end

endmodule

// File: rtl/cache_memory_lru_core.sv
// 4-way set-associative cache core with true-LRU replacement, no backing store.
// Optional feature: define CACHE_LRU_STATS_EN to add hit_count/miss_count outputs.
module cache_memory_lru_core
   import cache_lru_pkg::*;
#(
   parameter int unsigned CACHE_SIZE = DEF_CACHE_SIZE,
   parameter int unsigned INDEX_BITS = DEF_INDEX_BITS,
   parameter int unsigned TAG_BITS   = DEF_TAG_BITS,
   parameter int unsigned WAY_SIZE   = DEF_WAY_SIZE
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic        we,
   input  logic        re,
   output logic [31:0] data_out,
   output logic        hit
`ifdef CACHE_LRU_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   logic [INDEX_BITS-1:0]              idx_c;
   logic [TAG_BITS-1:0]                tag_c;
   logic                               hit_c;
   logic [WAY_BITS-1:0]                hit_way_c;
   logic [WAY_BITS-1:0]                victim_c;
   logic [WAY_BITS-1:0]                access_way_c;
   logic [NUM_WAYS-1:0][AGE_BITS-1:0]  ages_next_c;

   logic [NUM_WAYS-1:0]                valid_q  [CACHE_SIZE];
   logic [NUM_WAYS-1:0][AGE_BITS-1:0]  age_q    [CACHE_SIZE];
   logic [TAG_BITS-1:0]                tag_mem  [CACHE_SIZE][WAY_SIZE];
   logic [DATA_BITS-1:0]               data_mem [CACHE_SIZE][WAY_SIZE];

   assign idx_c = addr[INDEX_BITS-1:0];
   assign tag_c = addr[INDEX_BITS +: TAG_BITS];

   // Tag compare across the indexed set.
   always_comb begin
      hit_c     = 1'b0;
      hit_way_c = '0;
      for (int w = 0; w < int'(NUM_WAYS); w++) begin
         if (valid_q[idx_c][w] && (tag_mem[idx_c][w] == tag_c)) begin
            hit_c     = 1'b1;
            hit_way_c = way_t'(w);
         end
      end
   end

   // Writes that miss go to the victim; everything else touches the hit way.
   assign access_way_c = (we && !hit_c) ? victim_c : hit_way_c;

   lru_age_update u_lru_age_update (
      .ages        (age_q[idx_c]),
      .valid       (valid_q[idx_c]),
      .access_way  (access_way_c),
      .ages_next_c (ages_next_c),
      .victim_c    (victim_c)
   );

   // Control state: valid bits, ages, registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < int'(CACHE_SIZE); s++) begin
            valid_q[s] <= '0;
            age_q[s]   <= RESET_AGES;
         end
         data_out <= '0;
         hit      <= 1'b0;
      end else if (we) begin
         valid_q[idx_c][access_way_c] <= 1'b1;
         age_q[idx_c]                 <= ages_next_c;
         hit                          <= hit_c;
      end else if (re) begin
         if (hit_c) begin
            age_q[idx_c] <= ages_next_c;
            data_out     <= data_mem[idx_c][hit_way_c];
            hit          <= 1'b1;
         end else begin
            data_out <= '0;
            hit      <= 1'b0;
         end
      end else begin
         hit <= 1'b0;
      end
   end

   // Tag and data arrays carry no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (we) begin
         tag_mem[idx_c][access_way_c]  <= tag_c;
         data_mem[idx_c][access_way_c] <= data_in;
      end
   end

`ifdef CACHE_LRU_STATS_EN
   // Access outcome counters, free-running with natural wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (we || re) begin
         if (hit_c) begin
            hit_count <= hit_count + 32'd1;
         end else begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cache_memory_lru_core.sv
// Directed self-checking bench for cache_memory_lru_core.
module tb_cache_memory_lru_core;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic        we;
   logic        re;
   logic [31:0] data_out;
   logic        hit;
`ifdef CACHE_LRU_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int checks;
   int failures;

   cache_memory_lru_core dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .data_in  (data_in),
      .we       (we),
      .re       (re),
      .data_out (data_out),
      .hit      (hit)
`ifdef CACHE_LRU_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One access sampled on the next rising edge; outputs settle by return.
   task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      we = w; re = r; addr = a; data_in = d;
      @(posedge clk);
      #1;
      we = 1'b0; re = 1'b0;
   endtask

   task automatic test_reset;
      checks++;
      if (hit !== 1'b0) begin
         failures++; $display("FAIL reset_hit got=%b exp=0", hit);
      end
      checks++;
      if (data_out !== 32'h0) begin
         failures++; $display("FAIL reset_data got=%h exp=00000000", data_out);
      end
   endtask

   task automatic test_read_miss;
      drive(1'b0, 1'b1, 32'h55, 32'h0);
      checks++;
      if (hit !== 1'b0) begin
         failures++; $display("FAIL miss55_hit got=%b exp=0", hit);
      end
      checks++;
      if (data_out !== 32'h0) begin
         failures++; $display("FAIL miss55_data got=%h exp=00000000", data_out);
      end
   endtask

   task automatic test_fill_read;
      logic [31:0] a [4];
      logic [31:0] d [4];
      a = '{32'h0, 32'h4, 32'h8, 32'hC};
      d = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, a[i], d[i]);
         checks++;
         if (hit !== 1'b0) begin
            failures++; $display("FAIL fill_wr_hit addr=%h got=%b exp=0", a[i], hit);
         end
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, a[i], 32'h0);
         checks++;
         if (hit !== 1'b1 || data_out !== d[i]) begin
            failures++;
            $display("FAIL fill_rd addr=%h got hit=%b data=%h exp hit=1 data=%h", a[i], hit, data_out, d[i]);
         end
      end
   endtask

   task automatic test_more_sets;
      logic [31:0] a [4];
      logic [31:0] d [4];
      drive(1'b1, 1'b0, 32'h10, 32'hEEEEEEEE);
      drive(1'b1, 1'b0, 32'h14, 32'hFFFFFFFF);
      a = '{32'h10, 32'h14, 32'h0, 32'h4};
      d = '{32'hEEEEEEEE, 32'hFFFFFFFF, 32'hAAAAAAAA, 32'hBBBBBBBB};
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, a[i], 32'h0);
         checks++;
         if (hit !== 1'b1 || data_out !== d[i]) begin
            failures++;
            $display("FAIL sets_rd addr=%h got hit=%b data=%h exp hit=1 data=%h", a[i], hit, data_out, d[i]);
         end
      end
   endtask

   task automatic test_idle;
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      @(posedge clk);
      #1;
      checks++;
      if (hit !== 1'b0) begin
         failures++; $display("FAIL idle_hit got=%b exp=0", hit);
      end
      checks++;
      if (data_out !== 32'hCCCCCCCC) begin
         failures++; $display("FAIL idle_hold got=%h exp=cccccccc", data_out);
      end
   endtask

   task automatic test_lru_eviction;
      // Set 0 already holds tag 0 in way0, so this write hits.
      drive(1'b1, 1'b0, 32'h000, 32'd1);
      checks++;
      if (hit !== 1'b1) begin
         failures++; $display("FAIL evict_wr0_hit got=%b exp=1", hit);
      end
      drive(1'b1, 1'b0, 32'h100, 32'd2);
      drive(1'b1, 1'b0, 32'h200, 32'd3);
      drive(1'b1, 1'b0, 32'h300, 32'd4);
      drive(1'b0, 1'b1, 32'h000, 32'h0);
      checks++;
      if (hit !== 1'b1 || data_out !== 32'd1) begin
         failures++; $display("FAIL evict_rd0 got hit=%b data=%h exp hit=1 data=00000001", hit, data_out);
      end
      // Ages now way0=0 way1=3 way2=2 way3=1: way1 (0x100) is the victim.
      drive(1'b1, 1'b0, 32'h400, 32'd5);
      checks++;
      if (hit !== 1'b0) begin
         failures++; $display("FAIL evict_wr400_hit got=%b exp=0", hit);
      end
      drive(1'b0, 1'b1, 32'h100, 32'h0);
      checks++;
      if (hit !== 1'b0 || data_out !== 32'h0) begin
         failures++; $display("FAIL evict_rd100 got hit=%b data=%h exp hit=0 data=00000000", hit, data_out);
      end
      drive(1'b0, 1'b1, 32'h000, 32'h0);
      checks++;
      if (hit !== 1'b1 || data_out !== 32'd1) begin
         failures++; $display("FAIL evict_rd000 got hit=%b data=%h exp hit=1 data=00000001", hit, data_out);
      end
      drive(1'b0, 1'b1, 32'h200, 32'h0);
      checks++;
      if (hit !== 1'b1 || data_out !== 32'd3) begin
         failures++; $display("FAIL evict_rd200 got hit=%b data=%h exp hit=1 data=00000003", hit, data_out);
      end
      drive(1'b0, 1'b1, 32'h400, 32'h0);
      checks++;
      if (hit !== 1'b1 || data_out !== 32'd5) begin
         failures++; $display("FAIL evict_rd400 got hit=%b data=%h exp hit=1 data=00000005", hit, data_out);
      end
   endtask

   task automatic test_write_priority;
      drive(1'b1, 1'b1, 32'h8, 32'h12345678);
      checks++;
      if (hit !== 1'b1) begin
         failures++; $display("FAIL wrprio_hit got=%b exp=1", hit);
      end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      checks++;
      if (hit !== 1'b1 || data_out !== 32'h12345678) begin
         failures++; $display("FAIL wrprio_rd got hit=%b data=%h exp hit=1 data=12345678", hit, data_out);
      end
   endtask

   task automatic test_reset_clears;
      logic [31:0] a [5];
      a = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h400};
      // Reset held across an edge that also carries a write.
      @(negedge clk);
      reset = 1'b1; we = 1'b1; addr = 32'h8; data_in = 32'hDEADBEEF;
      @(posedge clk);
      #1;
      checks++;
      if (hit !== 1'b0 || data_out !== 32'h0) begin
         failures++; $display("FAIL rst_outs got hit=%b data=%h exp hit=0 data=00000000", hit, data_out);
      end
      @(negedge clk);
      reset = 1'b0; we = 1'b0;
`ifdef CACHE_LRU_STATS_EN
      checks++;
      if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
         failures++; $display("FAIL rst_stats got hits=%0d misses=%0d exp 0 0", hit_count, miss_count);
      end
`endif
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, a[i], 32'h0);
         checks++;
         if (hit !== 1'b0 || data_out !== 32'h0) begin
            failures++;
            $display("FAIL rst_rd addr=%h got hit=%b data=%h exp hit=0 data=00000000", a[i], hit, data_out);
         end
      end
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b1; we = 1'b0; re = 1'b0; addr = '0; data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_read_miss();
      test_fill_read();
      test_more_sets();
      test_idle();
      test_lru_eviction();
      test_write_priority();
      test_reset_clears();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
